onehot_index_stage: RTL

ONEHOT_INDEX_STAGE -- requirements
Module: onehot_index_stage

---
 rtl/onehot_pkg.sv | 22 ++
 rtl/onehot_lsb_enc.sv | 30 +++
 rtl/onehot_index_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/onehot_pkg.sv
// Shared types and constants for the one-hot index stage.
// The error counter width lives here even though the counter only exists under ONEHOT_ERR_CNT_EN.
package onehot_pkg;

  localparam int ONEHOT_WIDTH_DEF = 32;
  localparam int ERR_CNT_W        = 16;

  // Wide enough for the largest legal WIDTH (64); the stage slices it down to IDXW.
  localparam int IDX_MAX_W = 6;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] index;
    logic                 onehot;
    logic                 zero;
  } onehot_res_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage : onehot_pkg

// File: rtl/onehot_lsb_enc.sv
// Combinational classifier: lowest-set-bit index plus one-hot and all-zero flags.
// Holds no state; the registering is done by onehot_index_stage.
module onehot_lsb_enc
  import onehot_pkg::*;
#(
  parameter int WIDTH = ONEHOT_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  output onehot_res_t      res_o
);

  logic [WIDTH-1:0] data_minus_one;

  assign data_minus_one = data_i - WIDTH'(1);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the loop infers a latch.
    res_o        = '0;
    res_o.zero   = (data_i == '0);
    // x & (x-1) clears the lowest set bit; nothing left means at most one bit was set.
    res_o.onehot = (data_i != '0) && ((data_i & data_minus_one) == '0);
    // Scan from the top so the lowest set bit is written last and wins.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) begin
        res_o.index = IDX_MAX_W'(i);
      end
    end
  end

endmodule : onehot_lsb_enc

// File: rtl/onehot_index_stage.sv
// Single-entry registered stage that encodes the lowest set bit of a vector.
// Define ONEHOT_ERR_CNT_EN to add the saturating non-one-hot error counter (err_count).
module onehot_index_stage
  import onehot_pkg::*;
#(
  parameter  int WIDTH = ONEHOT_WIDTH_DEF,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      out_index,
  output logic                 out_onehot,
  output logic                 out_zero,
  input  logic                 err_clr
`ifdef ONEHOT_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("onehot_index_stage: WIDTH must be in 2..64");
  end

  stage_state_e state_q;
  onehot_res_t  res_q;
  onehot_res_t  enc_res;
  logic         accept;
  logic         xfer;

  onehot_lsb_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .data_i (in_data),
    .res_o  (enc_res)
  );

  // Ready looks through the output register so a draining entry can be refilled in the same cycle.
  assign in_ready  = (state_q == ST_EMPTY) || out_ready;
  assign out_valid = (state_q == ST_FULL);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= ST_EMPTY;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (xfer && !accept) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
      // accept is only possible when the held result is leaving or absent, so it never overwrites a stalled one.
      if (accept) begin
        res_q <= enc_res;
      end
    end
  end

  assign out_index  = res_q.index[IDXW-1:0];
  assign out_onehot = res_q.onehot;
  assign out_zero   = res_q.zero;

`ifdef ONEHOT_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && !enc_res.onehot && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;

  logic unused_idx;
  assign unused_idx = ^res_q.index;
`else
  // Upper index bits beyond IDXW and err_clr have no sink in this build.
  logic unused_idx;
  assign unused_idx = ^{res_q.index, err_clr};
`endif

endmodule : onehot_index_stage
